// File: rtl/mul_pkg.sv
// Shared types and defaults for the HI/LO multiply path.
package mul_pkg;

  localparam int MUL_LAT_DEF = 6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef logic [63:0] prod_t;

endpackage

// File: rtl/hilo_mul_unit_mul.sv
// Pipelined 32x32 signed multiplier: inputs sampled on one edge, product at z LAT edges later.
module Mul
  import mul_pkg::*;
#(
  parameter int LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output prod_t       z
);

  prod_t pipe [LAT];
  prod_t prod;

  assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign z = pipe[LAT-1];

endmodule

// File: rtl/hilo_mul_unit.sv
// EX-stage MULT/MULTU sequencer and HI/LO register owner, with MTHI/MTLO and core stall.
//   state | meaning
//   IDLE  | HI/LO stable; accepts start_i and MTHI/MTLO writes
//   WAIT  | operands held on Mul; count tracks pipeline until the product is captured
module hilo_mul_unit
  import mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic        rd_req_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o
);

  localparam int CW = $clog2(MUL_LAT + 2);

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          op_signed;
  prod_t         z;
  logic [31:0]   hi_fix;
  logic          last;

  Mul #(.LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .z   (z)
  );

  // Mul is signed-only; MULTU recovers the unsigned high word by adding back
  // the operand that was sign-misread as negative.
  always_comb begin
    hi_fix = z[63:32];
    if (!op_signed) begin
      if (op_a[31]) hi_fix = hi_fix + op_b;
      if (op_b[31]) hi_fix = hi_fix + op_a;
    end
  end

  assign last    = (state == WAIT) && (count == CW'(1));
  assign stall_o = busy_o & (start_i | rd_req_i | mthi_i | mtlo_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_a      <= a_i;
            op_b      <= b_i;
            op_signed <= signed_i;
            count     <= CW'(MUL_LAT + 1);
            busy_o    <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          count <= count - CW'(1);
          if (last) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // MT writes only land while idle; a same-cycle start is later overwritten by the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (last) begin
      hi_o <= hi_fix;
      lo_o <= z[31:0];
    end else if (state == IDLE) begin
      if (mthi_i) hi_o <= wdata_i;
      if (mtlo_i) lo_o <= wdata_i;
    end
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench for hilo_mul_unit: latency, MULT/MULTU results, MT writes, stall and reset abort.
module tb_hilo_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        rd_req_i = 1'b0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;

  int total = 0;
  int bad = 0;

  hilo_mul_unit #(.MUL_LAT(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .wdata_i  (wdata_i),
    .rd_req_i (rd_req_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply and count edges after the capture edge until done_o (bounded).
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int busy_n);
    start_i  = 1'b1;
    signed_i = s;
    a_i      = a;
    b_i      = b;
    step();
    start_i = 1'b0;
    lat     = 0;
    busy_n  = 0;
    while (!done_o && lat < 20) begin
      if (busy_o) busy_n++;
      step();
      lat++;
    end
    if (!done_o) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    total++; if (hi_o !== 32'h0)  begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); end
    total++; if (lo_o !== 32'h0)  begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_signed_neg1();
    int lat, bn;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bn);
    total++; if (lat !== 7) begin bad++; $display("FAIL neg1_latency got=%0d exp=7", lat); end
    total++; if (bn !== 7)  begin bad++; $display("FAIL neg1_busy_cycles got=%0d exp=7", bn); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL neg1_busy_at_done got=%b exp=0", busy_o); end
    total++; if (hi_o !== 32'h0000_0000) begin bad++; $display("FAIL neg1_hi got=%h exp=%h", hi_o, 32'h0); end
    total++; if (lo_o !== 32'h0000_0001) begin bad++; $display("FAIL neg1_lo got=%h exp=%h", lo_o, 32'h1); end
    step();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL neg1_done_pulse got=%b exp=0", done_o); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bn);
    total++; if (lat !== 7) begin bad++; $display("FAIL multu_latency got=%0d exp=7", lat); end
    total++; if (hi_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=%h", hi_o, 32'hFFFF_FFFE); end
    total++; if (lo_o !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=%h", lo_o, 32'h1); end
    // issued in the done cycle
    run_mul(32'h0000_0003, 32'hFFFF_FFFE, 1'b1, lat, bn);
    total++; if (lat !== 7) begin bad++; $display("FAIL b2b_latency got=%0d exp=7", lat); end
    total++; if (hi_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_hi got=%h exp=%h", hi_o, 32'hFFFF_FFFF); end
    total++; if (lo_o !== 32'hFFFF_FFFA) begin bad++; $display("FAIL b2b_lo got=%h exp=%h", lo_o, 32'hFFFF_FFFA); end
    run_mul(32'h8000_0000, 32'h0000_0002, 1'b0, lat, bn);
    total++; if (hi_o !== 32'h0000_0001) begin bad++; $display("FAIL multu_msb_hi got=%h exp=%h", hi_o, 32'h1); end
    total++; if (lo_o !== 32'h0000_0000) begin bad++; $display("FAIL multu_msb_lo got=%h exp=%h", lo_o, 32'h0); end
    step();
  endtask

  task automatic test_ignored_start();
    int n;
    start_i  = 1'b1;
    signed_i = 1'b1;
    a_i      = 32'd5;
    b_i      = 32'd7;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL idle_start_stall got=%b exp=0", stall_o); end
    step();
    start_i = 1'b0;
    step();
    step();
    start_i = 1'b1;
    a_i     = 32'd2;
    b_i     = 32'd2;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wait_start_stall got=%b exp=1", stall_o); end
    step();
    start_i = 1'b0;
    n = 3;
    while (!done_o && n < 20) begin
      step();
      n++;
    end
    total++; if (n !== 7) begin bad++; $display("FAIL ignored_start_latency got=%0d exp=7", n); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL ignored_start_hi got=%h exp=%h", hi_o, 32'h0); end
    total++; if (lo_o !== 32'h23) begin bad++; $display("FAIL ignored_start_lo got=%h exp=%h", lo_o, 32'h23); end
    step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ignored_start_rerun got=%b exp=0", busy_o); end
  endtask

  task automatic test_mt();
    int lat, bn;
    mthi_i  = 1'b1;
    mtlo_i  = 1'b1;
    wdata_i = 32'h1234_5678;
    rd_req_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL idle_mt_stall got=%b exp=0", stall_o); end
    step();
    mthi_i   = 1'b0;
    mtlo_i   = 1'b0;
    rd_req_i = 1'b0;
    total++; if (hi_o !== 32'h1234_5678) begin bad++; $display("FAIL mt_both_hi got=%h exp=%h", hi_o, 32'h1234_5678); end
    total++; if (lo_o !== 32'h1234_5678) begin bad++; $display("FAIL mt_both_lo got=%h exp=%h", lo_o, 32'h1234_5678); end
    mtlo_i  = 1'b1;
    wdata_i = 32'h9ABC_DEF0;
    step();
    mtlo_i = 1'b0;
    total++; if (lo_o !== 32'h9ABC_DEF0) begin bad++; $display("FAIL mtlo_lo got=%h exp=%h", lo_o, 32'h9ABC_DEF0); end
    total++; if (hi_o !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=%h", hi_o, 32'h1234_5678); end
    // MTHI together with start: lands now, product overwrites later
    mthi_i   = 1'b1;
    wdata_i  = 32'h0000_0055;
    start_i  = 1'b1;
    signed_i = 1'b1;
    a_i      = 32'd4;
    b_i      = 32'd9;
    step();
    mthi_i  = 1'b0;
    start_i = 1'b0;
    total++; if (hi_o !== 32'h55) begin bad++; $display("FAIL mt_with_start_hi got=%h exp=%h", hi_o, 32'h55); end
    step();
    mtlo_i  = 1'b1;
    wdata_i = 32'hDEAD_BEEF;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wait_mtlo_stall got=%b exp=1", stall_o); end
    step();
    mtlo_i = 1'b0;
    total++; if (lo_o !== 32'h9ABC_DEF0) begin bad++; $display("FAIL wait_mtlo_ignored got=%h exp=%h", lo_o, 32'h9ABC_DEF0); end
    rd_req_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wait_rdreq_stall got=%b exp=1", stall_o); end
    rd_req_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wait_no_req_stall got=%b exp=0", stall_o); end
    lat = 2;
    while (!done_o && lat < 20) begin
      step();
      lat++;
    end
    total++; if (lat !== 7) begin bad++; $display("FAIL mt_mul_latency got=%0d exp=7", lat); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL mt_mul_hi got=%h exp=%h", hi_o, 32'h0); end
    total++; if (lo_o !== 32'd36) begin bad++; $display("FAIL mt_mul_lo got=%h exp=%h", lo_o, 32'd36); end
    step();
    bn = 0;
  endtask

  task automatic test_reset_midflight();
    int lat, bn, seen;
    start_i  = 1'b1;
    signed_i = 1'b1;
    a_i      = 32'd6;
    b_i      = 32'd6;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    total++; if (hi_o !== 32'h0)  begin bad++; $display("FAIL abort_hi got=%h exp=%h", hi_o, 32'h0); end
    total++; if (lo_o !== 32'h0)  begin bad++; $display("FAIL abort_lo got=%h exp=%h", lo_o, 32'h0); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o) seen++;
      step();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    total++; if (lo_o !== 32'h0) begin bad++; $display("FAIL abort_lo_kept got=%h exp=%h", lo_o, 32'h0); end
    run_mul(32'd2, 32'd3, 1'b1, lat, bn);
    total++; if (lat !== 7) begin bad++; $display("FAIL post_reset_latency got=%0d exp=7", lat); end
    total++; if (lo_o !== 32'd6) begin bad++; $display("FAIL post_reset_lo got=%h exp=%h", lo_o, 32'd6); end
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL post_reset_hi got=%h exp=%h", hi_o, 32'h0); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed_neg1();
    test_back_to_back();
    test_ignored_start();
    test_mt();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
